mem_stream_seq: RTL and testbench
=================================

Name: mem_stream_seq

Overview:
- AXI-Lite master sequencer that drives the stream-buffer memory block's register file to run one complete stream transfer per command.
- Per command it performs three steps:
  - program stream size (reg 0x004);
  - arm stream write or stream read (reg 0x000);
  - count completed AXI-Stream beats on the active stream, then disarm (write 0 to reg 0x000), which rewinds the buffer pointer.
- Sits between a host/DMA command source and the buffer's AXI-Lite slave port, on the same clock.

Parameters:
- BASE_ADDR, 32'h0000_0000, base of the buffer register space.
- TIMEOUT, 1024, max idle cycles in RUN with no beat before aborting. Valid range 2..65535.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_dir  in  1  0 = stream into buffer (arm 0x1), 1 = stream out of buffer (arm 0x2).
- cmd_len  in  9  beat count, 0..256.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at command end.
- err  out  1  valid with done: BRESP != 0 or timeout.
- M_AXI_AWADDR  out  32  write address.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  constant 4'hf.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- wr_tvalid  in  1  tap of the stream into the buffer.
- wr_tready  in  1  tap of the stream into the buffer.
- rd_tvalid  in  1  tap of the stream out of the buffer.
- rd_tready  in  1  tap of the stream out of the buffer.

Behaviour:
- Reset values (async assert, sync release): state IDLE; all VALIDs 0; BREADY 0; busy 0; done 0; err 0; beat counter 0; timer 0; AWADDR/WDATA 0.
- Command accept: in IDLE, cmd_valid high latches dir and len, clears the sticky error, and moves to SZ_REQ.
- Write phases, each a REQ state followed by a RSP state:
  - On REQ entry, AWVALID and WVALID rise together in the same cycle.
  - Each VALID drops independently after its own handshake.
  - Both VALIDs are held until their handshake; neither drops early.
  - When both handshakes are done (same or different cycles), go to RSP with BREADY = 1.
  - RSP exits on BVALID. BRESP != 0 sets the sticky error.
- State sequence:
  - IDLE -> SZ_REQ/SZ_RSP (addr BASE+0x004, data {23'b0, len}).
  - -> ARM_REQ/ARM_RSP (addr BASE+0x000, data dir ? 2 : 1).
  - -> RUN -> STOP_REQ/STOP_RSP (addr BASE+0x000, data 0) -> FIN -> IDLE.
- Error handling: on BRESP error in SZ or ARM, skip RUN and go straight to STOP_REQ.
- RUN:
  - Count beats on the selected tap only: tvalid & tready.
  - Leave RUN when count == len. The comparison uses the registered count, so RUN lasts at least 1 cycle.
  - len = 0: RUN exits on its first cycle.
  - Timer clears on every beat and increments otherwise. Reaching TIMEOUT sets the sticky error and exits to STOP_REQ.
  - Beats on the tap after count == len are ignored.
- FIN: done = 1 and err = sticky error for exactly 1 cycle; busy is still 1. Next cycle returns to IDLE (cmd_ready = 1).
- Command back-to-back: a command presented in the same cycle as FIN is not accepted until IDLE.
- Reset mid-operation: everything returns to reset values at once. No disarm write is issued.

Decomposition:
- Shared package holds:
  - register offset constants: REG_CTRL = 12'h000, REG_SIZE = 12'h004;
  - arm codes: ARM_SWRITE = 2'b01, ARM_SREAD = 2'b10;
  - state enum.
- One sub-module, axil_single_write: one-shot AW/W/B write engine. Inputs start, addr, data; outputs busy, resp_done, resp_err. Used for all three write phases; the top-level FSM selects the address and data.

Test Plan:
- dir = 0, len = 8, slave ready always, 8 tap beats spaced 1 cycle apart -> writes in order (0x004, 8), (0x000, 1), (0x000, 0); done = 1 with err = 0; busy falls the cycle after done.
- dir = 1, len = 4, AWREADY delayed 3 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID held 3 cycles; arm data = 2; done after the 4th rd beat; wr-tap beats during RUN are not counted.
- len = 0 -> exactly three writes; RUN lasts 1 cycle; done, err = 0.
- BRESP = 2'b10 on the size write -> no arm write; stop write issued; done with err = 1.
- TIMEOUT = 16, len = 5, only 3 beats delivered -> timeout 16 cycles after the 3rd beat; stop write; done with err = 1.
- Assert reset while in ARM_REQ -> AWVALID, WVALID, busy and cmd_ready drop immediately (cmd_ready 0 during reset). After release: IDLE, cmd_ready = 1, no done pulse.

Source files
------------

// File: rtl/mem_stream_seq_pkg.sv
// Shared constants and types for the stream-buffer transfer sequencer.
package mem_stream_seq_pkg;

  localparam logic [11:0] REG_CTRL   = 12'h000;
  localparam logic [11:0] REG_SIZE   = 12'h004;

  localparam logic [1:0]  ARM_SWRITE = 2'b01;
  localparam logic [1:0]  ARM_SREAD  = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SZ_REQ,
    ST_SZ_RSP,
    ST_ARM_REQ,
    ST_ARM_RSP,
    ST_RUN,
    ST_STOP_REQ,
    ST_STOP_RSP,
    ST_FIN
  } state_e;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [11:0] off);
    return base + {20'b0, off};
  endfunction

endpackage

// File: rtl/mem_stream_seq_if.sv
// AXI-Lite write-channel bundle between the sequencer and the buffer register file.
interface mem_stream_seq_if;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
endinterface

// File: rtl/mem_stream_seq_axil_single_write.sv
// One-shot AXI-Lite write engine: AW and W raised together, each dropped on its own
// handshake, then BREADY held until the response arrives.
module axil_single_write (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        busy,
  output logic        req_done,
  output logic        resp_done,
  output logic        resp_err,
  mem_stream_seq_if.master m_axi
);

  logic        aw_valid_q, aw_valid_d;
  logic        w_valid_q, w_valid_d;
  logic        bready_q, bready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        aw_left, w_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      bready_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      bready_q   <= bready_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    bready_d   = bready_q;
    addr_d     = addr_q;
    data_d     = data_q;
    req_done   = 1'b0;
    resp_done  = 1'b0;
    resp_err   = 1'b0;
    aw_left    = aw_valid_q & ~m_axi.M_AXI_AWREADY;
    w_left     = w_valid_q & ~m_axi.M_AXI_WREADY;

    if (aw_valid_q || w_valid_q) begin
      aw_valid_d = aw_left;
      w_valid_d  = w_left;
      if (!aw_left && !w_left) begin
        req_done = 1'b1;
        bready_d = 1'b1;
      end
    end

    if (bready_q && m_axi.M_AXI_BVALID) begin
      bready_d  = 1'b0;
      resp_done = 1'b1;
      resp_err  = (m_axi.M_AXI_BRESP != 2'b00);
    end

    // the sequencer may start the next write in the same cycle the previous response lands
    if (start) begin
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
      addr_d     = addr;
      data_d     = data;
    end
  end

  assign busy                 = aw_valid_q | w_valid_q | bready_q;
  assign m_axi.M_AXI_AWADDR   = addr_q;
  assign m_axi.M_AXI_AWVALID  = aw_valid_q;
  assign m_axi.M_AXI_WDATA    = data_q;
  assign m_axi.M_AXI_WSTRB    = 4'hf;
  assign m_axi.M_AXI_WVALID   = w_valid_q;
  assign m_axi.M_AXI_BREADY   = bready_q;

endmodule

// File: rtl/mem_stream_seq.sv
// Runs one stream-buffer transfer per command: program size, arm, count beats, disarm.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// SZ_REQ   | size write address/data in flight
// SZ_RSP   | waiting for size write response
// ARM_REQ  | arm write address/data in flight
// ARM_RSP  | waiting for arm write response
// RUN      | counting beats on the selected tap, idle timer running
// STOP_REQ | disarm write address/data in flight
// STOP_RSP | waiting for disarm write response
// FIN      | done pulse with sticky error
module mem_stream_seq
  import mem_stream_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 1024
) (
  input  logic       S_AXI_ACLK,
  input  logic       S_AXI_ARESETN,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [8:0] cmd_len,
  output logic       busy,
  output logic       done,
  output logic       err,
  mem_stream_seq_if.master m_axi,
  input  logic       wr_tvalid,
  input  logic       wr_tready,
  input  logic       rd_tvalid,
  input  logic       rd_tready
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic        dir_q, dir_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;

  logic        wr_start;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_busy, wr_req_done, wr_resp_done, wr_resp_err;
  logic        beat;

  axil_single_write u_wr (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .start     (wr_start),
    .addr      (wr_addr),
    .data      (wr_data),
    .busy      (wr_busy),
    .req_done  (wr_req_done),
    .resp_done (wr_resp_done),
    .resp_err  (wr_resp_err),
    .m_axi     (m_axi)
  );

  assign beat = dir_q ? (rd_tvalid & rd_tready) : (wr_tvalid & wr_tready);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    err_d    = err_q;
    wr_start = 1'b0;
    wr_addr  = reg_addr(BASE_ADDR, REG_CTRL);
    wr_data  = '0;
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_d    = cmd_dir;
          len_d    = cmd_len;
          err_d    = 1'b0;
          state_d  = ST_SZ_REQ;
          wr_start = 1'b1;
          wr_addr  = reg_addr(BASE_ADDR, REG_SIZE);
          wr_data  = {23'b0, cmd_len};
        end
      end
      ST_SZ_REQ:  if (wr_req_done) state_d = ST_SZ_RSP;
      ST_SZ_RSP: begin
        if (wr_resp_done) begin
          wr_start = 1'b1;
          if (wr_resp_err) begin
            err_d   = 1'b1;
            state_d = ST_STOP_REQ;
          end else begin
            state_d = ST_ARM_REQ;
            wr_data = {30'b0, dir_q ? ARM_SREAD : ARM_SWRITE};
          end
        end
      end
      ST_ARM_REQ: if (wr_req_done) state_d = ST_ARM_RSP;
      ST_ARM_RSP: begin
        if (wr_resp_done) begin
          if (wr_resp_err) begin
            err_d    = 1'b1;
            state_d  = ST_STOP_REQ;
            wr_start = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
            timer_d = '0;
          end
        end
      end
      ST_RUN: begin
        // registered count compare: RUN always lasts at least one cycle, extra beats ignored
        if (cnt_q == len_q) begin
          state_d  = ST_STOP_REQ;
          wr_start = 1'b1;
        end else if (beat) begin
          cnt_d   = cnt_q + 9'd1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
          if (timer_d == TIMEOUT_C) begin
            err_d    = 1'b1;
            state_d  = ST_STOP_REQ;
            wr_start = 1'b1;
          end
        end
      end
      ST_STOP_REQ: if (wr_req_done) state_d = ST_STOP_RSP;
      ST_STOP_RSP: begin
        if (wr_resp_done) begin
          if (wr_resp_err) err_d = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE) && S_AXI_ARESETN;
  assign busy      = (state_q != ST_IDLE) || wr_busy;

endmodule

// File: tb/tb_mem_stream_seq.sv
// Scoreboard bench for mem_stream_seq: expected register writes queued per command,
// observed writes captured from the AXI-Lite bus and popped against them.
module tb_mem_stream_seq;
  import mem_stream_seq_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          TMO  = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [8:0] cmd_len = '0;
  logic       cmd_ready, busy, done, err;
  logic       wr_tvalid = 1'b0, wr_tready = 1'b0, rd_tvalid = 1'b0, rd_tready = 1'b0;

  mem_stream_seq_if bus ();

  mem_stream_seq #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dir       (cmd_dir),
    .cmd_len       (cmd_len),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .m_axi         (bus),
    .wr_tvalid     (wr_tvalid),
    .wr_tready     (wr_tready),
    .rd_tvalid     (rd_tvalid),
    .rd_tready     (rd_tready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  aw_len_q[$];
  int  w_len_q[$];

  logic        aw_got = 1'b0, w_got = 1'b0, aw_prev = 1'b0;
  logic [31:0] aw_addr_c, w_data_c;
  int          aw_hi = 0, w_hi = 0;
  int          b_cnt = 0, done_cnt = 0, run_cycles = 0, cyc = 0;
  int          last_beat_cyc = 0, last_aw_rise = 0;
  int          wr_idx = 0, err_wr_idx = -1, aw_delay = 0, aw_wait = 0;
  logic        b_pend = 1'b0, b_taken = 1'b0, cur_dir = 1'b0;
  logic [1:0]  b_resp_next = 2'b00;

  // bus monitor: samples pre-edge values at every rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got = 1'b0; w_got = 1'b0; aw_prev = 1'b0;
      aw_hi = 0; w_hi = 0; b_pend = 1'b0; b_taken = 1'b0;
    end else begin
      cyc++;
      if (bus.M_AXI_AWVALID) aw_hi++;
      if (bus.M_AXI_WVALID) w_hi++;
      if (bus.M_AXI_AWVALID && !aw_prev) last_aw_rise = cyc;
      aw_prev = bus.M_AXI_AWVALID;
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        aw_got = 1'b1; aw_addr_c = bus.M_AXI_AWADDR; aw_len_q.push_back(aw_hi); aw_hi = 0;
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        w_got = 1'b1; w_data_c = bus.M_AXI_WDATA; w_len_q.push_back(w_hi); w_hi = 0;
      end
      if (aw_got && w_got) begin
        obs_q.push_back({aw_addr_c, w_data_c});
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
        b_resp_next = (wr_idx == err_wr_idx) ? 2'b10 : 2'b00;
        wr_idx++;
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
        b_cnt++; b_taken = 1'b1;
      end
      if (busy && !bus.M_AXI_AWVALID && !bus.M_AXI_WVALID && !bus.M_AXI_BREADY && !done)
        run_cycles++;
      if (done) done_cnt++;
      if (cur_dir ? (rd_tvalid && rd_tready) : (wr_tvalid && wr_tready)) last_beat_cyc = cyc;
    end
  end

  // slave responder: drives ready/response at the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
      bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = 2'b00; aw_wait = 0;
    end else begin
      if (bus.M_AXI_AWVALID) begin
        bus.M_AXI_AWREADY = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        bus.M_AXI_AWREADY = 1'b0;
        aw_wait = 0;
      end
      bus.M_AXI_WREADY = bus.M_AXI_WVALID;
      if (b_taken) begin
        bus.M_AXI_BVALID = 1'b0; b_taken = 1'b0;
      end else if (b_pend && !bus.M_AXI_BVALID) begin
        bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = b_resp_next; b_pend = 1'b0;
      end
    end
  end

  task automatic issue(input logic d, input logic [8:0] l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = d; cmd_len = l; cur_dir = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_b(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (b_cnt >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_beat(input logic d);
    @(negedge clk);
    if (d) begin rd_tvalid = 1'b1; rd_tready = 1'b1; end
    else   begin wr_tvalid = 1'b1; wr_tready = 1'b1; end
    @(negedge clk);
    if (d) begin rd_tvalid = 1'b0; rd_tready = 1'b0; end
    else   begin wr_tvalid = 1'b0; wr_tready = 1'b0; end
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); aw_len_q.delete(); w_len_q.delete();
    run_cycles = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({cmd_ready, busy, done, err, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY} !== 7'b0) begin
      fails++; $display("FAIL reset_ctl: got %b want 0000000",
        {cmd_ready, busy, done, err, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY});
    end
    tests++;
    if (bus.M_AXI_AWADDR !== 32'h0 || bus.M_AXI_WDATA !== 32'h0 || bus.M_AXI_WSTRB !== 4'hf) begin
      fails++; $display("FAIL reset_bus: got addr %h data %h strb %h want 0/0/f",
        bus.M_AXI_AWADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release: got ready %b busy %b want 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_stream_in();
    bit ok; int b0, d0; wr_t e, o;
    clear_sb(); b0 = b_cnt; d0 = done_cnt;
    exp_q.push_back({BASE + 32'h4, 32'd8});
    exp_q.push_back({BASE, 32'd1});
    exp_q.push_back({BASE, 32'd0});
    issue(1'b0, 9'd8);
    wait_b(b0 + 2, ok);
    for (int i = 0; i < 8; i++) pulse_beat(1'b0);
    wait_done(ok);
    tests++;
    if (!ok || err !== 1'b0) begin
      fails++; $display("FAIL in_done: got done_seen %0d err %b want 1/0", ok, err);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || done_cnt != d0 + 1) begin
      fails++; $display("FAIL in_after: got busy %b ready %b dones %0d want 0/1/%0d", busy, cmd_ready, done_cnt - d0, 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL in_write: got none want %h/%h", e.addr, e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL in_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL in_extra: got %0d extra writes want 0", obs_q.size()); end
  endtask

  task automatic test_stream_out_aw_delay();
    bit ok; int b0, d0; wr_t e, o;
    clear_sb(); b0 = b_cnt; aw_delay = 2;
    exp_q.push_back({BASE + 32'h4, 32'd4});
    exp_q.push_back({BASE, 32'd2});
    exp_q.push_back({BASE, 32'd0});
    issue(1'b1, 9'd4);
    wait_b(b0 + 2, ok);
    d0 = done_cnt;
    wr_tvalid = 1'b1; wr_tready = 1'b1;
    for (int i = 0; i < 3; i++) pulse_beat(1'b1);
    repeat (2) @(negedge clk);
    tests++;
    if (done_cnt != d0 || busy !== 1'b1) begin
      fails++; $display("FAIL out_early_done: got dones %0d busy %b want 0/1", done_cnt - d0, busy);
    end
    pulse_beat(1'b1);
    wr_tvalid = 1'b0; wr_tready = 1'b0;
    wait_done(ok);
    tests++;
    if (!ok || err !== 1'b0) begin
      fails++; $display("FAIL out_done: got done_seen %0d err %b want 1/0", ok, err);
    end
    tests++;
    if (aw_len_q.size() < 1 || w_len_q.size() < 1 || aw_len_q[0] != 3 || w_len_q[0] != 1) begin
      fails++; $display("FAIL out_valid_len: got aw %0d w %0d want 3/1",
        aw_len_q.size() > 0 ? aw_len_q[0] : -1, w_len_q.size() > 0 ? w_len_q[0] : -1);
    end
    aw_delay = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL out_write: got none want %h/%h", e.addr, e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL out_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL out_extra: got %0d extra writes want 0", obs_q.size()); end
  endtask

  task automatic test_len_zero();
    bit ok; wr_t e, o;
    clear_sb();
    exp_q.push_back({BASE + 32'h4, 32'd0});
    exp_q.push_back({BASE, 32'd1});
    exp_q.push_back({BASE, 32'd0});
    issue(1'b0, 9'd0);
    wait_done(ok);
    tests++;
    if (!ok || err !== 1'b0 || run_cycles != 1) begin
      fails++; $display("FAIL len0: got done_seen %0d err %b run %0d want 1/0/1", ok, err, run_cycles);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL len0_write: got none want %h/%h", e.addr, e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL len0_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL len0_extra: got %0d extra writes want 0", obs_q.size()); end
  endtask

  task automatic test_bresp_error();
    bit ok; wr_t e, o;
    clear_sb(); err_wr_idx = wr_idx;
    exp_q.push_back({BASE + 32'h4, 32'd8});
    exp_q.push_back({BASE, 32'd0});
    issue(1'b0, 9'd8);
    wait_done(ok);
    tests++;
    if (!ok || err !== 1'b1 || run_cycles != 0) begin
      fails++; $display("FAIL bresp: got done_seen %0d err %b run %0d want 1/1/0", ok, err, run_cycles);
    end
    err_wr_idx = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL bresp_write: got none want %h/%h", e.addr, e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL bresp_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL bresp_extra: got %0d extra writes want 0", obs_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok; int b0; wr_t e, o;
    clear_sb(); b0 = b_cnt;
    exp_q.push_back({BASE + 32'h4, 32'd5});
    exp_q.push_back({BASE, 32'd1});
    exp_q.push_back({BASE, 32'd0});
    issue(1'b0, 9'd5);
    wait_b(b0 + 2, ok);
    for (int i = 0; i < 3; i++) pulse_beat(1'b0);
    wait_done(ok);
    tests++;
    if (!ok || err !== 1'b1) begin
      fails++; $display("FAIL timeout_done: got done_seen %0d err %b want 1/1", ok, err);
    end
    // the stop write's AWVALID is first sampled one edge after the timeout transition
    tests++;
    if (last_aw_rise - last_beat_cyc != TMO + 1) begin
      fails++; $display("FAIL timeout_gap: got %0d want %0d", last_aw_rise - last_beat_cyc, TMO + 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL timeout_write: got none want %h/%h", e.addr, e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL timeout_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL timeout_extra: got %0d extra writes want 0", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok; int d0; wr_t e, o;
    clear_sb(); d0 = done_cnt;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({BASE + 32'h4, 32'd0});
      exp_q.push_back({BASE, 32'd1});
      exp_q.push_back({BASE, 32'd0});
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 9'd0; cur_dir = 1'b0;
    wait_done(ok);
    tests++;
    if (!ok || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL b2b_fin: got done_seen %0d ready %b busy %b want 1/0/1", ok, cmd_ready, busy);
    end
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_idle: got ready %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(ok);
    tests++;
    if (!ok || err !== 1'b0 || done_cnt != d0 + 2) begin
      fails++; $display("FAIL b2b_second: got done_seen %0d err %b dones %0d want 1/0/2", ok, err, done_cnt - d0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL b2b_write: got none want %h/%h", e.addr, e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL b2b_write: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL b2b_extra: got %0d extra writes want 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_op();
    bit ok; int b0, d0;
    clear_sb(); b0 = b_cnt; aw_delay = 10;
    issue(1'b0, 9'd3);
    wait_b(b0 + 1, ok);
    tests++;
    if (!ok || bus.M_AXI_AWVALID !== 1'b1) begin
      fails++; $display("FAIL rst_mid_arm: got size_resp %0d awvalid %b want 1/1", ok, bus.M_AXI_AWVALID);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, busy, cmd_ready} !== 4'b0000) begin
      fails++; $display("FAIL rst_mid_drop: got aw %b w %b busy %b ready %b want 0000",
        bus.M_AXI_AWVALID, bus.M_AXI_WVALID, busy, cmd_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; aw_delay = 0; d0 = done_cnt;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_idle: got ready %b busy %b want 1/0", cmd_ready, busy);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (done_cnt != d0 || bus.M_AXI_AWVALID !== 1'b0) begin
      fails++; $display("FAIL rst_mid_quiet: got dones %0d awvalid %b want 0/0", done_cnt - d0, bus.M_AXI_AWVALID);
    end
  endtask

  initial begin
    test_reset();
    test_stream_in();
    test_stream_out_aw_delay();
    test_len_zero();
    test_bresp_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
